// File: rtl/display_page_sequencer.sv
// Rotates NUM_PAGES binary values onto one DIGITS-wide BCD field, with hold/step and a flashing alarm page.
// Latency: one clk_2Hz tick from the page value input to disp_bcd; page_idx/blank are registered.
// No backpressure: free-running tick domain. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_page_sequencer #(
  parameter int NUM_PAGES = 4,
  parameter int VAL_W     = 8,
  parameter int DIGITS    = 2,
  parameter int DWELL     = 6,
  parameter int FLASH_MIN = 4,
  localparam int PW       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                       clk_2Hz,
  input  logic                       rst,
  input  logic [NUM_PAGES*VAL_W-1:0] page_vals,
  input  logic [NUM_PAGES-1:0]       page_en,
  input  logic                       hold,
  input  logic                       step,
  input  logic                       alarm,
  input  logic [PW-1:0]              alarm_page,
  output logic [PW-1:0]              page_idx,
  output logic [DIGITS*4-1:0]        disp_bcd,
  output logic                       blank,
  output logic                       over
);

  localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int FW = (FLASH_MIN > 0) ? $clog2(FLASH_MIN + 1) : 1;
  localparam int RW = (VAL_W < 4) ? 4 : VAL_W;

  localparam logic [1:0] ST_ROTATE = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_ALARM  = 2'd2;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [FW-1:0] FLASH_TGT  = FW'(FLASH_MIN);
  localparam logic [PW:0]   NP         = (PW + 1)'(NUM_PAGES);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    page_idx_q, page_idx_d;
  logic [DW-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
  logic             blank_q, blank_d;
  logic [VAL_W-1:0] snap_q, snap_d;

  logic [VAL_W-1:0] vals [NUM_PAGES];
  logic [PW-1:0]    nxt_idx;
  logic [PW-1:0]    alarm_idx;
  logic [FW-1:0]    flash_inc;
  logic [DIGITS*4-1:0] bcd;
  logic             over_c;

  // Unpack the flat page value bus into an indexable array.
  always_comb begin
    for (int p = 0; p < NUM_PAGES; p++) vals[p] = page_vals[p*VAL_W +: VAL_W];
  end

  // Next enabled page after the current one, wrapping; falls back to the current page.
  always_comb begin
    logic found;
    int   c;
    found   = 1'b0;
    nxt_idx = page_idx_q;
    for (int k = 1; k <= NUM_PAGES; k++) begin
      c = (int'(page_idx_q) + k) % NUM_PAGES;
      if (!found && page_en[PW'(c)]) begin
        found   = 1'b1;
        nxt_idx = PW'(c);
      end
    end
  end

  // Out-of-range alarm pages fall back to page 0; flash counter saturates at its target.
  always_comb begin
    alarm_idx = ({1'b0, alarm_page} >= NP) ? '0 : alarm_page;
    flash_inc = (flash_cnt_q >= FLASH_TGT) ? flash_cnt_q : flash_cnt_q + 1'b1;
  end

  // Sequencer FSM: alarm pre-empts everything, step beats dwell expiry, hold freezes the dwell count.
  always_comb begin
    state_d     = state_q;
    page_idx_d  = page_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    flash_cnt_d = flash_cnt_q;
    blank_d     = blank_q;
    case (state_q)
      ST_ALARM: begin
        // flash_inc counts the ticks already spent flashing including this one, so the alarm
        // page is shown for exactly FLASH_MIN ticks on a short alarm pulse.
        blank_d     = ~blank_q;
        flash_cnt_d = flash_inc;
        if (!alarm && (flash_inc >= FLASH_TGT)) begin
          state_d     = ST_ROTATE;
          dwell_cnt_d = '0;
          blank_d     = 1'b0;
        end
      end
      default: begin
        if (alarm) begin
          state_d     = ST_ALARM;
          page_idx_d  = alarm_idx;
          flash_cnt_d = '0;
          blank_d     = 1'b1;
        end else begin
          state_d = hold ? ST_HOLD : ST_ROTATE;
          blank_d = (page_en == '0);
          if (step || (!hold && (dwell_cnt_q == DWELL_LAST))) begin
            page_idx_d  = nxt_idx;
            dwell_cnt_d = '0;
          end else if (!hold) begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
      end
    endcase
    snap_d = vals[page_idx_d];
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_2Hz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ROTATE;
      page_idx_q  <= '0;
      dwell_cnt_q <= '0;
      flash_cnt_q <= '0;
      blank_q     <= 1'b0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      page_idx_q  <= page_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      blank_q     <= blank_d;
      snap_q      <= snap_d;
    end
  end

  // Decode the registered snapshot to BCD; values beyond the field saturate to all nines.
  always_comb begin
    logic [RW-1:0] rem;
    logic          lead;
    over_c = (64'(snap_q) > MAX_VAL);
    rem    = RW'(snap_q);
    bcd    = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd[d*4 +: 4] = over_c ? 4'h9 : 4'(rem % RW'(10));
      rem           = rem / RW'(10);
    end
    lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int d = DIGITS - 1; d > 0; d--) begin
      if (lead && (bcd[d*4 +: 4] == 4'h0)) bcd[d*4 +: 4] = 4'hF;
      else                                 lead = 1'b0;
    end
`else
    lead = lead & 1'b0;
`endif
  end

  assign page_idx = page_idx_q;
  assign blank    = blank_q;
  assign disp_bcd = bcd;
  assign over     = over_c;

endmodule
